hh_gate_update: RTL and testbench

//  Multi-channel Hodgkin-Huxley gating-variable integrator (m/h/n agnostic), one forward-Euler step per request.

---
 rtl/hh_gate_pkg.sv | 29 ++
 rtl/hh_gate_update_lut.sv | 43 ++++
 rtl/hh_gate_update.sv | 194 +++++++++++++++++++
 tb/tb_hh_gate_update.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hh_gate_pkg.sv
// Shared fixed-point widths, rate-table entry layout and FSM encoding for the HH gate integrator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hh_gate_pkg;

    localparam int G_W        = 16;              // gate, unsigned Q1.15
    localparam int R_W        = 16;              // alpha/beta, unsigned Q8.8 per ms
    localparam int DT_W       = 16;              // time step, unsigned Q0.16 ms
    localparam int PA_W       = R_W + G_W;       // rate * gate product, frac 23
    localparam int D_W        = PA_W + 2;        // signed difference of two products
    localparam int P_W        = D_W + DT_W;      // signed increment, frac 39
    localparam int STEP_SHIFT = 24;              // frac 39 -> frac 15

    localparam logic [G_W-1:0] ONE = 16'd32768;  // 1.0 in Q1.15

    typedef struct packed {
        logic [R_W-1:0] alpha;
        logic [R_W-1:0] beta;
    } rate_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_MUL,
        ST_DT,
        ST_WB
    } state_t;

endpackage

// File: rtl/hh_gate_update_lut.sv
// Rate table: LUT_DEPTH entries of {alpha,beta}, async reset to zero, one write port, registered read.
// Latency: read data valid the cycle after i_re; a same-address write in the i_re cycle returns the old entry.
// Backpressure: none; writes are accepted every cycle.
// Ports: i_we/i_waddr/i_wdat write an entry; i_re/i_raddr load o_rdat.
module hh_rate_lut import hh_gate_pkg::*; #(
    parameter int LUT_DEPTH = 64,
    parameter int AW        = $clog2(LUT_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  rate_t         i_wdat,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output rate_t         o_rdat
);

    rate_t r_tbl [LUT_DEPTH];
    rate_t r_rdat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_tbl[i] <= '0;
            end
        end else if (i_we) begin
            r_tbl[i_waddr] <= i_wdat;
        end
    end

    // Read samples the array before this edge's write lands (read-before-write).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdat <= '0;
        end else if (i_re) begin
            r_rdat <= r_tbl[i_raddr];
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/hh_gate_update.sv
// Multi-channel Hodgkin-Huxley gate integrator: one forward-Euler step of g per accepted request.
// Latency: accept in cycle 0 -> out_valid in cycle 4; 1 update per 5 cycles with out_ready held high.
// Backpressure: result held in WB until out_ready; in_ready low whenever busy or a clear is being applied.
// Ports: in_* request (channel, V, dt), g_clr clear-all, tbl_* rate-table write, out_* result handshake.
// Optional: define HH_GATE_SAT_CNT_EN to add sat_cnt, a saturating count of clamp events.
module hh_gate_update import hh_gate_pkg::*; #(
    parameter int N_CH      = 4,
    parameter int LUT_DEPTH = 64,
    parameter int V_MIN     = -100,
    parameter int V_SHIFT   = 2,
    parameter int G_INIT    = 1737,
    parameter int CW        = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int AW        = $clog2(LUT_DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW-1:0]   in_ch,
    input  logic [15:0]     in_v,
    input  logic [DT_W-1:0] dt,
    input  logic            g_clr,
    input  logic            tbl_we,
    input  logic [AW-1:0]   tbl_addr,
    input  logic [R_W-1:0]  tbl_alpha,
    input  logic [R_W-1:0]  tbl_beta,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_ch,
    output logic [G_W-1:0]  out_gate
`ifdef HH_GATE_SAT_CNT_EN
    ,
    output logic [15:0]     sat_cnt
`endif
);

    localparam logic [G_W-1:0]     G_RST   = G_W'(G_INIT);
    localparam logic signed [17:0] VMIN18  = 18'(V_MIN);
    localparam logic signed [17:0] IDX_MAX = 18'(LUT_DEPTH - 1);
    localparam logic signed [P_W-1:0] ONE_P = P_W'(ONE);

    state_t r_st, w_st_nxt;

    logic [CW-1:0]   r_ch;
    logic [15:0]     r_v;
    logic [DT_W-1:0] r_dt;
    logic [G_W-1:0]  r_g;
    logic [PA_W-1:0] r_pa, r_pb;
    logic [CW-1:0]   r_out_ch;
    logic [G_W-1:0]  r_out_gate;
    logic            r_clr_pend;
    logic [G_W-1:0]  r_gate [N_CH];

    logic            w_idle, w_clr_now, w_accept;
    logic signed [17:0] w_voff, w_vsh;
    logic [AW-1:0]   w_idx;
    rate_t           w_rate, w_tbl_wdat;
    logic [G_W-1:0]  w_omg;
    logic [PA_W-1:0] w_pa, w_pb;
    logic signed [D_W-1:0] w_d;
    logic signed [P_W-1:0] w_p, w_gsum;
    logic            w_lo, w_hi;
    logic [G_W-1:0]  w_gnext;

    // A clear (fresh or deferred) is applied only in IDLE and blocks acceptance that cycle.
    assign w_idle    = (r_st == ST_IDLE);
    assign w_clr_now = w_idle && (g_clr || r_clr_pend);
    assign in_ready  = w_idle && !g_clr && !r_clr_pend;
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_st <= ST_IDLE;
        else       r_st <= w_st_nxt;
    end

    always_comb begin
        w_st_nxt = r_st;
        case (r_st)
            ST_IDLE: if (w_accept) w_st_nxt = ST_RD;
            ST_RD:   w_st_nxt = ST_MUL;
            ST_MUL:  w_st_nxt = ST_DT;
            ST_DT:   w_st_nxt = ST_WB;
            ST_WB:   if (out_ready) w_st_nxt = ST_IDLE;
            default: w_st_nxt = ST_IDLE;
        endcase
    end

    // Table index from latched V: floor((V - V_MIN) / 2^V_SHIFT), clamped to the table.
    assign w_voff = $signed({{2{r_v[15]}}, r_v}) - VMIN18;
    assign w_vsh  = w_voff >>> V_SHIFT;

    always_comb begin
        w_idx = w_vsh[AW-1:0];
        if (w_vsh < 18'sd0)        w_idx = '0;
        else if (w_vsh > IDX_MAX)  w_idx = AW'(LUT_DEPTH - 1);
    end

    assign w_tbl_wdat = '{alpha: tbl_alpha, beta: tbl_beta};

    hh_rate_lut #(
        .LUT_DEPTH (LUT_DEPTH),
        .AW        (AW)
    ) u_lut (
        .clk     (clk),
        .reset   (reset),
        .i_we    (tbl_we),
        .i_waddr (tbl_addr),
        .i_wdat  (w_tbl_wdat),
        .i_re    (r_st == ST_RD),
        .i_raddr (w_idx),
        .o_rdat  (w_rate)
    );

    // MUL: alpha*(1-g) and beta*g, both exact unsigned 32-bit.
    assign w_omg = ONE - r_g;
    assign w_pa  = PA_W'(w_rate.alpha) * PA_W'(w_omg);
    assign w_pb  = PA_W'(w_rate.beta) * PA_W'(r_g);

    // DT: signed difference times dt; the Euler sum and clamp are folded in here so the
    // result is already registered on out_gate when WB is entered (cycle 4).
    assign w_d    = $signed({2'b00, r_pa}) - $signed({2'b00, r_pb});
    assign w_p    = $signed({{DT_W{w_d[D_W-1]}}, w_d}) * $signed({{D_W{1'b0}}, r_dt});
    assign w_gsum = $signed({{(P_W-G_W){1'b0}}, r_g}) + (w_p >>> STEP_SHIFT);
    assign w_lo   = (w_gsum < $signed({P_W{1'b0}}));
    assign w_hi   = (w_gsum > ONE_P);

    always_comb begin
        w_gnext = w_gsum[G_W-1:0];
        if (w_lo)      w_gnext = '0;
        else if (w_hi) w_gnext = ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ch       <= '0;
            r_v        <= '0;
            r_dt       <= '0;
            r_g        <= '0;
            r_pa       <= '0;
            r_pb       <= '0;
            r_out_ch   <= '0;
            r_out_gate <= '0;
            r_clr_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ch <= in_ch;
                r_v  <= in_v;
                r_dt <= dt;
            end
            if (r_st == ST_RD) r_g <= r_gate[r_ch];
            if (r_st == ST_MUL) begin
                r_pa <= w_pa;
                r_pb <= w_pb;
            end
            if (r_st == ST_DT) begin
                r_out_gate <= w_gnext;
                r_out_ch   <= r_ch;
            end
            if (w_clr_now)            r_clr_pend <= 1'b0;
            else if (g_clr && !w_idle) r_clr_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) r_gate[i] <= G_RST;
        end else if (w_clr_now) begin
            for (int i = 0; i < N_CH; i++) r_gate[i] <= G_RST;
        end else if (r_st == ST_DT) begin
            r_gate[r_ch] <= w_gnext;
        end
    end

    assign out_valid = (r_st == ST_WB);
    assign out_ch    = r_out_ch;
    assign out_gate  = r_out_gate;

`ifdef HH_GATE_SAT_CNT_EN
    logic [15:0] r_sat_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sat_cnt <= '0;
        end else if (w_clr_now) begin
            r_sat_cnt <= '0;
        end else if ((r_st == ST_DT) && (w_lo || w_hi) && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif

endmodule

// File: tb/tb_hh_gate_update.sv
// Directed bench for hh_gate_update with an expected-result queue and a reference Euler model.
// Latency: checks out_valid 3 edges after the accept edge (cycle 4).
// Backpressure: exercises out_ready low for 3 cycles.
module tb_hh_gate_update;

    localparam int N_CH      = 4;
    localparam int LUT_DEPTH = 64;
    localparam int CW        = 2;
    localparam int AW        = 6;
    localparam int G_INIT    = 1737;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [CW-1:0] in_ch;
    logic [15:0]   in_v, dt;
    logic          g_clr;
    logic          tbl_we;
    logic [AW-1:0] tbl_addr;
    logic [15:0]   tbl_alpha, tbl_beta;
    logic          out_valid, out_ready;
    logic [CW-1:0] out_ch;
    logic [15:0]   out_gate;
`ifdef HH_GATE_SAT_CNT_EN
    logic [15:0]   sat_cnt;
`endif

    hh_gate_update dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_v      (in_v),
        .dt        (dt),
        .g_clr     (g_clr),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_alpha (tbl_alpha),
        .tbl_beta  (tbl_beta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_gate  (out_gate)
`ifdef HH_GATE_SAT_CNT_EN
        ,
        .sat_cnt   (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_alpha [LUT_DEPTH];
    int m_beta  [LUT_DEPTH];
    int m_g     [N_CH];
    int m_sat;
    bit m_clr_pend;

    typedef struct { int ch; int gate; } exp_t;
    exp_t sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int m_idx(input int v);
        int d;
        d = v + 100;
        if (d < 0) return 0;
        d = d >>> 2;
        if (d > LUT_DEPTH - 1) return LUT_DEPTH - 1;
        return d;
    endfunction

    function automatic int m_step(input int g, input int a, input int b, input int dtv, output bit sat);
        longint pa, pb, p, g2;
        pa  = longint'(a) * longint'(32768 - g);
        pb  = longint'(b) * longint'(g);
        p   = (pa - pb) * longint'(dtv);
        g2  = longint'(g) + (p >>> 24);
        sat = (g2 < 0) || (g2 > 32768);
        if (g2 < 0) g2 = 0;
        if (g2 > 32768) g2 = 32768;
        return int'(g2);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N_CH; i++) m_g[i] = G_INIT;
        m_sat = 0;
    endtask

    task automatic tbl_write(input int a, input int al, input int be);
        tbl_we    = 1'b1;
        tbl_addr  = AW'(a);
        tbl_alpha = 16'(al);
        tbl_beta  = 16'(be);
        @(posedge clk); #1;
        tbl_we    = 1'b0;
        m_alpha[a] = al;
        m_beta[a]  = be;
    endtask

    // Issue one update, push its expected result, then wait for and check the DUT output.
    // clr_busy pulses g_clr during the RD cycle. The handshake completes only if out_ready=1.
    task automatic upd(input int ch, input int v, input int dtv, input bit clr_busy, input string tag);
        int   n, lat, ix;
        bit   sat;
        exp_t e;
        in_valid = 1'b1;
        in_ch    = CW'(ch);
        in_v     = 16'(v);
        dt       = 16'(dtv);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        ix     = m_idx(v);
        e.ch   = ch;
        e.gate = m_step(m_g[ch], m_alpha[ix], m_beta[ix], dtv, sat);
        m_g[ch] = e.gate;
        if (sat && m_sat < 65535) m_sat++;
        sb.push_back(e);
        lat = 0;
        while (!out_valid && lat < 20) begin
            g_clr = clr_busy && (lat == 0);
            @(posedge clk); #1;
            g_clr = 1'b0;
            lat++;
        end
        // Accept edge ends cycle 0; three more edges reach cycle 4.
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        if (out_valid) begin
            e = sb.pop_front();
            chk({tag, "_gate"}, 32'(out_gate), 32'(e.gate));
            chk({tag, "_ch"},   32'(out_ch),   32'(e.ch));
        end
        if (clr_busy) m_clr_pend = 1'b1;
        if (out_ready) begin
            @(posedge clk); #1;
            chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
            if (m_clr_pend) begin
                chk({tag, "_clr_rdy_low"}, 32'(in_ready), 32'd0);
                m_clear();
                m_clr_pend = 1'b0;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int seen;
        reset = 1'b1; in_valid = 1'b0; in_ch = '0; in_v = '0; dt = '0; g_clr = 1'b0;
        tbl_we = 1'b0; tbl_addr = '0; tbl_alpha = '0; tbl_beta = '0; out_ready = 1'b1;
        for (int i = 0; i < LUT_DEPTH; i++) begin m_alpha[i] = 0; m_beta[i] = 0; end
        m_clear();
        m_clr_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ch",    32'(out_ch),    32'd0);
        chk("rst_out_gate",  32'(out_gate),  32'd0);

        // Zero table: every channel stays at its initial value
        for (int c = 0; c < N_CH; c++) upd(c, -65, 16'h1000, 1'b0, "zero_rate");

        // Single Euler step: -40 mV -> index 15
        tbl_write(15, 16'h0100, 0);
        upd(0, -40, 16'h1000, 1'b0, "euler");
        chk("euler_const", 32'(out_gate), 32'd3676);

        // Clamp high then low on ch1
        tbl_write(20, 16'hFF00, 0);
        tbl_write(21, 0, 16'hFF00);
        upd(1, -20, 16'hFFFF, 1'b0, "clamp_hi");
        chk("clamp_hi_const", 32'(out_gate), 32'd32768);
        upd(1, -16, 16'hFFFF, 1'b0, "clamp_lo");
        chk("clamp_lo_const", 32'(out_gate), 32'd0);
`ifdef HH_GATE_SAT_CNT_EN
        chk("sat_cnt_two", 32'(sat_cnt), 32'd2);
`endif

        // V clamp: extreme potentials hit the table ends
        tbl_write(0, 16'h0200, 0);
        tbl_write(63, 0, 16'h0100);
        upd(2, -200, 16'h1000, 1'b0, "vclamp_lo");
        upd(3,  300, 16'h1000, 1'b0, "vclamp_hi");

        // g_clr in IDLE: drops in_ready that cycle, clears all channels
        in_valid = 1'b1; in_ch = 2'd3; in_v = 16'hFFBF; dt = 16'h1000;
        g_clr = 1'b1;
        #1 chk("idle_clr_rdy", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        g_clr = 1'b0; in_valid = 1'b0;
        m_clear();
`ifdef HH_GATE_SAT_CNT_EN
        chk("sat_cnt_clr", 32'(sat_cnt), 32'd0);
`endif
        upd(3, -65, 16'h1000, 1'b0, "after_clr");

        // Backpressure: result held for 3 cycles
        out_ready = 1'b0;
        upd(0, -40, 16'h1000, 1'b0, "bp");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_vld",  32'(out_valid), 32'd1);
            chk("bp_hold_gate", 32'(out_gate),  32'(m_g[0]));
            chk("bp_hold_ch",   32'(out_ch),    32'd0);
            chk("bp_hold_rdy",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_vld", 32'(out_valid), 32'd0);
        chk("bp_rel_rdy", 32'(in_ready),  32'd1);

        // Reset while in DT: update discarded, everything back to reset values
        in_valid = 1'b1; in_ch = 2'd2; in_v = 16'hFFD8; dt = 16'h1000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        chk("mid_rst_vld",  32'(out_valid), 32'd0);
        chk("mid_rst_gate", 32'(out_gate),  32'd0);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < LUT_DEPTH; i++) begin m_alpha[i] = 0; m_beta[i] = 0; end
        m_clear();
        sb.delete();
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mid_rst_no_out", 32'(seen), 32'd0);
        upd(2, -65, 16'h1000, 1'b0, "mid_rst_state");

        // ch2 updates leave ch0 alone; deferred clear lands after the busy update
        tbl_write(15, 16'h0100, 0);
        upd(2, -40, 16'h1000, 1'b0, "ch2_a");
        upd(0, -65, 16'h1000, 1'b0, "ch0_untouched");
        upd(2, -40, 16'h1000, 1'b1, "ch2_busy_clr");
        upd(2, -65, 16'h1000, 1'b0, "ch2_after_defer");
`ifdef HH_GATE_SAT_CNT_EN
        chk("sat_cnt_end", 32'(sat_cnt), 32'(m_sat));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
